// File: rtl/evt_counter_bank.sv
// Multi-channel event counter bank with wrap/saturate modes and atomic snapshot.
// Each channel counts 0..max_in; snapshot captures pre-edge counts of all channels.
module evt_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NUM_CH-1:0]       evt_in,
    input  logic [NUM_CH-1:0]       clr_in,
    input  logic [NUM_CH-1:0]       load_in,
    input  logic [NUM_CH*WIDTH-1:0] load_val_in,
    input  logic [WIDTH-1:0]        max_in,
    input  logic [NUM_CH-1:0]       sat_in,
    input  logic                    snap_in,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]       wrap_out,
    output logic [NUM_CH-1:0]       sat_out,
    output logic [NUM_CH*WIDTH-1:0] snap_out,
    output logic                    snap_valid_out
);

    logic [NUM_CH-1:0][WIDTH-1:0] r_cnt;
    logic [NUM_CH-1:0][WIDTH-1:0] r_snap;
    logic [NUM_CH-1:0][WIDTH-1:0] w_ld;
    logic [NUM_CH-1:0][WIDTH-1:0] w_clamp;
    logic [NUM_CH-1:0]            w_term;
    logic [NUM_CH-1:0]            r_wrap;
    logic [NUM_CH-1:0]            r_sat;
    logic                         r_snap_v;

    assign w_ld = load_val_in;

    // ">=" so a count left above a lowered max_in is terminal on its next event
    always_comb begin
        w_clamp = '0;
        w_term  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clamp[i] = (w_ld[i] > max_in) ? max_in : w_ld[i];
            w_term[i]  = (r_cnt[i] >= max_in);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt    <= '0;
            r_snap   <= '0;
            r_wrap   <= '0;
            r_sat    <= '0;
            r_snap_v <= 1'b0;
        end else begin
            r_wrap <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_in[i]) begin
                    r_cnt[i] <= '0;
                    r_sat[i] <= 1'b0;
                end else if (load_in[i]) begin
                    r_cnt[i] <= w_clamp[i];
                    r_sat[i] <= 1'b0;
                end else if (evt_in[i]) begin
                    if (!w_term[i]) begin
                        r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                    end else if (sat_in[i]) begin
                        r_cnt[i] <= max_in;
                        r_sat[i] <= 1'b1;
                    end else begin
                        r_cnt[i]  <= '0;
                        r_sat[i]  <= 1'b0;
                        r_wrap[i] <= 1'b1;
                    end
                end
            end
            r_snap_v <= snap_in;
            if (snap_in) begin
                r_snap <= r_cnt;
            end
        end
    end

    assign count_out      = r_cnt;
    assign snap_out       = r_snap;
    assign wrap_out       = r_wrap;
    assign sat_out        = r_sat;
    assign snap_valid_out = r_snap_v;

endmodule

// File: tb/tb_evt_counter_bank.sv
// Directed table-driven bench for evt_counter_bank (NUM_CH=4, WIDTH=8).
// Vectors are applied on the falling edge and checked 1ns after the rising edge.
module tb_evt_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic          clk;
    logic          rst_n;
    logic [NCH-1:0] evt, clr, ld, sat;
    logic [31:0]   lv;
    logic [W-1:0]  mx;
    logic          snap;
    logic [31:0]   cnt_o;
    logic [NCH-1:0] wrap_o, sat_o;
    logic [31:0]   snap_o;
    logic          sv_o;

    int checks;
    int failures;

    evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .evt_in        (evt),
        .clr_in        (clr),
        .load_in       (ld),
        .load_val_in   (lv),
        .max_in        (mx),
        .sat_in        (sat),
        .snap_in       (snap),
        .count_out     (cnt_o),
        .wrap_out      (wrap_o),
        .sat_out       (sat_o),
        .snap_out      (snap_o),
        .snap_valid_out(sv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  evt;
        logic [3:0]  clr;
        logic [3:0]  ld;
        logic [3:0]  sat;
        logic [31:0] lv;
        logic [7:0]  mx;
        logic        snap;
        logic [31:0] cnt;
        logic [3:0]  wrap;
        logic [3:0]  satq;
        logic        sv;
        logic [31:0] snapq;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] p4(input int c0, input int c1,
                                       input int c2, input int c3);
        logic [7:0] a, b, c, d;
        a = 8'(c0);
        b = 8'(c1);
        c = 8'(c2);
        d = 8'(c3);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] r4(input int x);
        return p4(x, x, x, x);
    endfunction

    function automatic vec_t mk(
        input string nm,
        input logic [3:0] e, input logic [3:0] c,
        input logic [3:0] l, input logic [3:0] s,
        input logic [31:0] lval, input logic [7:0] m,
        input logic sn, input logic [31:0] ec,
        input logic [3:0] ew, input logic [3:0] es,
        input logic esv, input logic [31:0] esn);
        vec_t v;
        v.name = nm; v.evt = e; v.clr = c; v.ld = l; v.sat = s;
        v.lv = lval; v.mx = m; v.snap = sn;
        v.cnt = ec; v.wrap = ew; v.satq = es; v.sv = esv; v.snapq = esn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        evt  = v.evt;
        clr  = v.clr;
        ld   = v.ld;
        sat  = v.sat;
        lv   = v.lv;
        mx   = v.mx;
        snap = v.snap;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".cnt"},  cnt_o,  32'h0);
        chk({nm, ".wrap"}, 32'(wrap_o), 32'h0);
        chk({nm, ".sat"},  32'(sat_o),  32'h0);
        chk({nm, ".snap"}, snap_o, 32'h0);
        chk({nm, ".sv"},   32'(sv_o),   32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        evt = '0; clr = '0; ld = '0; sat = '0;
        lv = '0; mx = '0; snap = 1'b0;

        // basic wrap on ch0, max 9
        for (int k = 0; k < 12; k++)
            vq.push_back(mk($sformatf("basic%0d", k), 4'b0001, 4'b0, 4'b0,
                4'b0, 32'h0, 8'd9, 1'b0, p4((k + 1) % 10, 0, 0, 0),
                (k == 9) ? 4'b0001 : 4'b0, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("clr0", 4'b0, 4'b0001, 4'b0, 4'b0010, 32'h0, 8'd5,
            1'b0, r4(0), 4'b0, 4'b0, 1'b0, 32'h0));
        // saturate on ch1, max 5
        for (int k = 0; k < 8; k++)
            vq.push_back(mk($sformatf("sat%0d", k), 4'b0010, 4'b0, 4'b0,
                4'b0010, 32'h0, 8'd5, 1'b0,
                p4(0, (k + 1 > 5) ? 5 : k + 1, 0, 0),
                4'b0, (k >= 5) ? 4'b0010 : 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("satclr", 4'b0, 4'b0010, 4'b0, 4'b0010, 32'h0,
            8'd5, 1'b0, r4(0), 4'b0, 4'b0, 1'b0, 32'h0));
        // priority on ch2, max 50
        vq.push_back(mk("prio_clr", 4'b0100, 4'b0100, 4'b0100, 4'b0,
            p4(0, 0, 7, 0), 8'd50, 1'b0, r4(0), 4'b0, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("prio_ld", 4'b0100, 4'b0, 4'b0100, 4'b0,
            p4(0, 0, 200, 0), 8'd50, 1'b0, p4(0, 0, 50, 0), 4'b0, 4'b0,
            1'b0, 32'h0));
        vq.push_back(mk("ld_eqmax", 4'b0, 4'b0, 4'b0100, 4'b0100,
            p4(0, 0, 50, 0), 8'd50, 1'b0, p4(0, 0, 50, 0), 4'b0, 4'b0,
            1'b0, 32'h0));
        vq.push_back(mk("sat_at_max", 4'b0100, 4'b0, 4'b0, 4'b0100, 32'h0,
            8'd50, 1'b0, p4(0, 0, 50, 0), 4'b0, 4'b0100, 1'b0, 32'h0));
        vq.push_back(mk("unsat_wrap", 4'b0100, 4'b0, 4'b0, 4'b0, 32'h0,
            8'd50, 1'b0, r4(0), 4'b0100, 4'b0, 1'b0, 32'h0));
        // max_in shrink on ch3
        vq.push_back(mk("shr_ld", 4'b0, 4'b0, 4'b1000, 4'b0,
            p4(0, 0, 0, 40), 8'd50, 1'b0, p4(0, 0, 0, 40), 4'b0, 4'b0,
            1'b0, 32'h0));
        vq.push_back(mk("shr_hold", 4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 8'd10,
            1'b0, p4(0, 0, 0, 40), 4'b0, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("shr_wrap", 4'b1000, 4'b0, 4'b0, 4'b0, 32'h0, 8'd10,
            1'b0, r4(0), 4'b1000, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("shr_ld2", 4'b0, 4'b0, 4'b1000, 4'b0,
            p4(0, 0, 0, 40), 8'd50, 1'b0, p4(0, 0, 0, 40), 4'b0, 4'b0,
            1'b0, 32'h0));
        vq.push_back(mk("shr_sat", 4'b1000, 4'b0, 4'b0, 4'b1000, 32'h0,
            8'd10, 1'b0, p4(0, 0, 0, 10), 4'b0, 4'b1000, 1'b0, 32'h0));
        vq.push_back(mk("shr_clr", 4'b0, 4'b1000, 4'b0, 4'b0, 32'h0, 8'd10,
            1'b0, r4(0), 4'b0, 4'b0, 1'b0, 32'h0));
        // max_in = 0 on ch0
        vq.push_back(mk("m0_w1", 4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 8'd0,
            1'b0, r4(0), 4'b0001, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("m0_w2", 4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 8'd0,
            1'b0, r4(0), 4'b0001, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("m0_sat", 4'b0001, 4'b0, 4'b0, 4'b0001, 32'h0, 8'd0,
            1'b0, r4(0), 4'b0, 4'b0001, 1'b0, 32'h0));
        vq.push_back(mk("m0_unsat", 4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 8'd0,
            1'b0, r4(0), 4'b0001, 4'b0, 1'b0, 32'h0));
        // full-range rollover on ch0
        vq.push_back(mk("ff_ld", 4'b0, 4'b0, 4'b0001, 4'b0,
            p4(254, 0, 0, 0), 8'd255, 1'b0, p4(254, 0, 0, 0), 4'b0, 4'b0,
            1'b0, 32'h0));
        vq.push_back(mk("ff_top", 4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b0, p4(255, 0, 0, 0), 4'b0, 4'b0, 1'b0, 32'h0));
        vq.push_back(mk("ff_roll", 4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b0, r4(0), 4'b0001, 4'b0, 1'b0, 32'h0));
        // snapshot coherence, all channels counting
        for (int k = 0; k < 3; k++)
            vq.push_back(mk($sformatf("snp_run%0d", k), 4'b1111, 4'b0, 4'b0,
                4'b0, 32'h0, 8'd255, 1'b0, r4(k + 1), 4'b0, 4'b0, 1'b0,
                32'h0));
        vq.push_back(mk("snp_a", 4'b1111, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b1, r4(4), 4'b0, 4'b0, 1'b1, r4(3)));
        vq.push_back(mk("snp_idle", 4'b1111, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b0, r4(5), 4'b0, 4'b0, 1'b0, r4(3)));
        vq.push_back(mk("snp_b2b1", 4'b1111, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b1, r4(6), 4'b0, 4'b0, 1'b1, r4(5)));
        vq.push_back(mk("snp_b2b2", 4'b1111, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b1, r4(7), 4'b0, 4'b0, 1'b1, r4(6)));
        vq.push_back(mk("snp_end", 4'b1111, 4'b0, 4'b0, 4'b0, 32'h0, 8'd255,
            1'b0, r4(8), 4'b0, 4'b0, 1'b0, r4(6)));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            chk({vq[i].name, ".cnt"},  cnt_o,  vq[i].cnt);
            chk({vq[i].name, ".wrap"}, 32'(wrap_o), 32'(vq[i].wrap));
            chk({vq[i].name, ".sat"},  32'(sat_o),  32'(vq[i].satq));
            chk({vq[i].name, ".sv"},   32'(sv_o),   32'(vq[i].sv));
            chk({vq[i].name, ".snap"}, snap_o, vq[i].snapq);
        end

        // async reset in the middle of a cycle while counting
        @(negedge clk);
        evt = 4'b1111; clr = '0; ld = '0; sat = 4'b0001;
        mx = 8'd2; snap = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        sat = 4'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel1.cnt", cnt_o, r4(1));
        @(posedge clk);
        #1;
        chk("arst_rel2.cnt", cnt_o, r4(2));
        chk("arst_rel2.sat", 32'(sat_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
